tank_btn_ctrl: RTL and testbench

Input conditioning stage that sits directly upstream of the player tank controller (`mytank_app`). It turns the five raw board buttons (`bt_w`, `bt_a`, `bt_s`, `bt_d`, `bt_st`) into clean signals in the 100 MHz `clk` domain:
- a debounced movement request with last-pressed-wins direction;
- a sticky shoot request that holds until the consumer acknowledges it.

This lets the slow 4 Hz game logic catch presses it would otherwise miss.

---
 rtl/tank_btn_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_tank_btn_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tank_btn_ctrl
//
// Purpose: conditions the five raw board buttons for the player tank
// controller. Each button is synchronised (2 flops), debounced (counter per
// button), and edge-detected. Direction keys drive a last-pressed-wins
// movement request. The shoot key drives a sticky request that holds until
// the consumer acknowledges it, so slow game logic cannot miss a press.
//
// Optional feature: define BTN_AUTOFIRE_EN to add an autofire counter that
// re-asserts sht_req every AUTOFIRE_CYCLES cycles while st stays held.
// The AUTOFIRE_CYCLES parameter exists only in that build.
//
// Ports:
//   clk        in   system clock (100 MHz)
//   rst        in   synchronous active-high reset
//   bt_w/a/s/d in   raw asynchronous direction buttons, active-high
//   bt_st      in   raw asynchronous shoot button, active-high
//   btn_db     out  debounced levels {st,d,s,a,w}, bit0 = w
//   mv_en      out  1 while a direction key is held (FSM in MOVE)
//   mv_dir     out  00 up(w), 01 down(s), 10 left(a), 11 right(d)
//   sht_req    out  sticky shoot request
//   sht_ack    in   one-cycle acknowledge from the consumer, clears sht_req
//   dbg_state  out  direction FSM state (0 IDLE, 1 MOVE)
//
// Handshake: sht_req is a level "valid"; sht_ack is a one-cycle "taken"
// strobe. sht_req drops on the cycle after sht_ack is sampled high unless a
// new request arrives in that same cycle, in which case it stays high.
// Requests never queue: extra presses while sht_req = 1 are absorbed.
// -----------------------------------------------------------------------------
module tank_btn_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
`ifdef BTN_AUTOFIRE_EN
   ,
   parameter int AUTOFIRE_CYCLES = 25_000_000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bt_w,
   input  logic       bt_a,
   input  logic       bt_s,
   input  logic       bt_d,
   input  logic       bt_st,
   output logic [4:0] btn_db,
   output logic       mv_en,
   output logic [1:0] mv_dir,
   output logic       sht_req,
   input  logic       sht_ack,
   output logic       dbg_state
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MOVE = 1'b1
   } mv_state_t;

   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [4:0]       raw;
   logic [4:0]       s1_q, s1_d, s2_q, s2_d;
   logic [4:0]       db_q, db_d, db_dly_q, db_dly_d;
   logic [CNT_W-1:0] cnt_q [5];
   logic [CNT_W-1:0] cnt_d [5];
   logic [3:0]       dir_rise, dir_fall;
   logic             st_rise;
   logic             sht_set;
   mv_state_t        state_q, state_d;
   logic [1:0]       mv_dir_q, mv_dir_d;
   logic             sht_req_q, sht_req_d;

   assign raw = {bt_st, bt_d, bt_s, bt_a, bt_w};

   // Highest-priority key in a {d,s,a,w} vector: w > s > a > d.
   function automatic logic [1:0] pri_dir(input logic [3:0] v);
      if (v[0])      return 2'b00;
      else if (v[2]) return 2'b01;
      else if (v[1]) return 2'b10;
      else           return 2'b11;
   endfunction

   // Map a direction code back to its button bit in {d,s,a,w}.
   function automatic logic [3:0] dir_mask(input logic [1:0] d);
      case (d)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0100;
         2'b10:   return 4'b0010;
         default: return 4'b1000;
      endcase
   endfunction

   assign dir_rise = db_q[3:0] & ~db_dly_q[3:0];
   assign dir_fall = ~db_q[3:0] & db_dly_q[3:0];
   assign st_rise  = db_q[4] & ~db_dly_q[4];

`ifdef BTN_AUTOFIRE_EN
   localparam int AF_W = (AUTOFIRE_CYCLES > 2) ? $clog2(AUTOFIRE_CYCLES) : 1;
   localparam logic [AF_W-1:0] AF_MAX = AF_W'(AUTOFIRE_CYCLES - 1);

   logic [AF_W-1:0] af_cnt_q, af_cnt_d;
   logic            af_tick;

   // Held in reset on the edge-triggered request cycle so the first repeat
   // lands exactly AUTOFIRE_CYCLES cycles after it.
   always_comb begin
      af_tick  = 1'b0;
      af_cnt_d = '0;
      if (db_q[4] && !st_rise) begin
         if (af_cnt_q == AF_MAX) begin
            af_tick = 1'b1;
         end else begin
            af_cnt_d = af_cnt_q + AF_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) af_cnt_q <= '0;
      else     af_cnt_q <= af_cnt_d;
   end

   assign sht_set = st_rise | af_tick;
`else
   assign sht_set = st_rise;
`endif

   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      db_dly_d = db_q;
      db_d     = db_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = '0;
         // Count only while the synchronised level disagrees with the
         // accepted one; any agreement restarts qualification.
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_MAX) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end

      state_d  = state_q;
      mv_dir_d = mv_dir_q;
      case (state_q)
         ST_IDLE: begin
            if (|dir_rise) begin
               state_d  = ST_MOVE;
               mv_dir_d = pri_dir(dir_rise);
            end
         end
         ST_MOVE: begin
            // A new press outranks any release in the same cycle.
            if (|dir_rise) begin
               mv_dir_d = pri_dir(dir_rise);
            end else if (|(dir_fall & dir_mask(mv_dir_q))) begin
               if (|db_q[3:0]) mv_dir_d = pri_dir(db_q[3:0]);
               else            state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      sht_req_d = sht_req_q;
      if (sht_ack) sht_req_d = 1'b0;
      if (sht_set) sht_req_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         db_q      <= '0;
         db_dly_q  <= '0;
         state_q   <= ST_IDLE;
         mv_dir_q  <= 2'b00;
         sht_req_q <= 1'b0;
         for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         db_q      <= db_d;
         db_dly_q  <= db_dly_d;
         state_q   <= state_d;
         mv_dir_q  <= mv_dir_d;
         sht_req_q <= sht_req_d;
         for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign btn_db    = db_q;
   assign mv_en     = (state_q == ST_MOVE);
   assign mv_dir    = mv_dir_q;
   assign sht_req   = sht_req_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tank_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tank_btn_ctrl: directed bench for tank_btn_ctrl with DEBOUNCE_CYCLES = 4,
// CNT_W = 3, AUTOFIRE_CYCLES = 8. Outputs are packed as
// {btn_db[4:0], mv_en, mv_dir[1:0], sht_req} and compared one cycle-step at a
// time, sampled 1 ns after the rising edge. Inputs driven after edge k are
// first sampled by edge k+1 ("E0"); btn_db changes at E5, FSM/shoot at E6.
// -----------------------------------------------------------------------------
module tb_tank_btn_ctrl;

   localparam int DB = 4;
   localparam int CW = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       bt_w, bt_a, bt_s, bt_d, bt_st;
   logic [4:0] btn_db;
   logic       mv_en;
   logic [1:0] mv_dir;
   logic       sht_req;
   logic       sht_ack;
   logic       dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   tank_btn_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (CW)
`ifdef BTN_AUTOFIRE_EN
      ,
      .AUTOFIRE_CYCLES(8)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bt_w     (bt_w),
      .bt_a     (bt_a),
      .bt_s     (bt_s),
      .bt_d     (bt_d),
      .bt_st    (bt_st),
      .btn_db   (btn_db),
      .mv_en    (mv_en),
      .mv_dir   (mv_dir),
      .sht_req  (sht_req),
      .sht_ack  (sht_ack),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];
   string      tag_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;

   function automatic logic [8:0] pk(input logic [4:0] db, input logic en,
                                     input logic [1:0] dir, input logic req);
      return {db, en, dir, req};
   endfunction

   function automatic logic [8:0] observed();
      return {btn_db, mv_en, mv_dir, sht_req};
   endfunction

   task automatic expect_out(input string tag, input logic [8:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check_out();
      logic [8:0] e;
      logic [8:0] o;
      string      t;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_underflow: observed %b required an expected entry", observed());
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observed();
      assert (o === e) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b (db,en,dir,req)", t, o, e);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input logic [4:0] v);
      bt_w  = v[0];
      bt_a  = v[1];
      bt_s  = v[2];
      bt_d  = v[3];
      bt_st = v[4];
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst     = 1'b1;
      sht_ack = 1'b0;
      set_btn(5'h1F);

      // 1: reset with all buttons held, then qualification after release of rst
      expect_out("reset_all_zero", pk(5'h00, 1'b0, 2'b00, 1'b0));
      step(3);
      check_out();
      rst = 1'b0;
      expect_out("t1_db_not_yet", pk(5'h00, 1'b0, 2'b00, 1'b0));
      step(5);
      check_out();
      expect_out("t1_db_rise", pk(5'h1F, 1'b0, 2'b00, 1'b0));
      step(1);
      check_out();
      expect_out("t1_move_w_shoot", pk(5'h1F, 1'b1, 2'b00, 1'b1));
      step(1);
      check_out();
      set_btn(5'h00);
      sht_ack = 1'b1;
      expect_out("t1_ack_clears", pk(5'h1F, 1'b1, 2'b00, 1'b0));
      step(1);
      sht_ack = 1'b0;
      check_out();
      expect_out("t1_db_fall", pk(5'h00, 1'b1, 2'b00, 1'b0));
      step(5);
      check_out();
      expect_out("t1_idle", pk(5'h00, 1'b0, 2'b00, 1'b0));
      step(1);
      check_out();

      // 2: 3-cycle glitch on d is rejected
      set_btn(5'h08);
      for (int i = 0; i < 3; i++) begin
         expect_out("t2_glitch_high", pk(5'h00, 1'b0, 2'b00, 1'b0));
         step(1);
         check_out();
      end
      set_btn(5'h00);
      for (int i = 0; i < 8; i++) begin
         expect_out("t2_glitch_after", pk(5'h00, 1'b0, 2'b00, 1'b0));
         step(1);
         check_out();
      end

      // 3: w, then d on top, release d, release w
      set_btn(5'h01);
      expect_out("t3_w", pk(5'h01, 1'b1, 2'b00, 1'b0));
      step(7);
      check_out();
      set_btn(5'h09);
      expect_out("t3_d_db_only", pk(5'h09, 1'b1, 2'b00, 1'b0));
      step(6);
      check_out();
      expect_out("t3_d_retarget", pk(5'h09, 1'b1, 2'b11, 1'b0));
      step(1);
      check_out();
      set_btn(5'h01);
      expect_out("t3_rel_d_back_w", pk(5'h01, 1'b1, 2'b00, 1'b0));
      step(7);
      check_out();
      set_btn(5'h00);
      expect_out("t3_idle", pk(5'h00, 1'b0, 2'b00, 1'b0));
      step(7);
      check_out();

      // 4: a and s together -> s wins; release s -> a; release a -> dir held
      set_btn(5'h06);
      expect_out("t4_as_pri_s", pk(5'h06, 1'b1, 2'b01, 1'b0));
      step(7);
      check_out();
      set_btn(5'h02);
      expect_out("t4_rel_s_to_a", pk(5'h02, 1'b1, 2'b10, 1'b0));
      step(7);
      check_out();
      set_btn(5'h00);
      expect_out("t4_idle_dir_held", pk(5'h00, 1'b0, 2'b10, 1'b0));
      step(7);
      check_out();

      // 5: sticky shoot, ack, ack while idle, ack coinciding with new edge
      set_btn(5'h10);
      expect_out("t5_req_set", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(7);
      check_out();
      set_btn(5'h00);
      expect_out("t5_sticky", pk(5'h00, 1'b0, 2'b10, 1'b1));
      step(9);
      check_out();
      sht_ack = 1'b1;
      expect_out("t5_ack_clears", pk(5'h00, 1'b0, 2'b10, 1'b0));
      step(1);
      sht_ack = 1'b0;
      check_out();
      sht_ack = 1'b1;
      expect_out("t5_ack_when_idle", pk(5'h00, 1'b0, 2'b10, 1'b0));
      step(1);
      sht_ack = 1'b0;
      check_out();
      expect_out("t5_still_idle", pk(5'h00, 1'b0, 2'b10, 1'b0));
      step(2);
      check_out();
      set_btn(5'h10);
      expect_out("t5_req_again", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(7);
      check_out();
      set_btn(5'h00);
      expect_out("t5_req_held", pk(5'h00, 1'b0, 2'b10, 1'b1));
      step(7);
      check_out();
      set_btn(5'h10);
      expect_out("t5_pre_coincide", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(6);
      check_out();
      sht_ack = 1'b1;
      expect_out("t5_ack_vs_edge", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(1);
      sht_ack = 1'b0;
      check_out();
      set_btn(5'h00);
      sht_ack = 1'b1;
      expect_out("t5_final_clear", pk(5'h10, 1'b0, 2'b10, 1'b0));
      step(1);
      sht_ack = 1'b0;
      check_out();
      expect_out("t5_released", pk(5'h00, 1'b0, 2'b10, 1'b0));
      step(8);
      check_out();

`ifdef BTN_AUTOFIRE_EN
      // 6: autofire every 8 cycles while st held; tick beats a same-cycle ack
      set_btn(5'h10);
      expect_out("t6_first", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(7);
      check_out();
      sht_ack = 1'b1;
      expect_out("t6_ack1", pk(5'h10, 1'b0, 2'b10, 1'b0));
      step(1);
      sht_ack = 1'b0;
      check_out();
      expect_out("t6_before_tick", pk(5'h10, 1'b0, 2'b10, 1'b0));
      step(6);
      check_out();
      expect_out("t6_tick1", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(1);
      check_out();
      expect_out("t6_hold_req", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(7);
      check_out();
      sht_ack = 1'b1;
      expect_out("t6_tick_vs_ack", pk(5'h10, 1'b0, 2'b10, 1'b1));
      step(1);
      sht_ack = 1'b0;
      check_out();
      set_btn(5'h00);
      sht_ack = 1'b1;
      expect_out("t6_ack2", pk(5'h10, 1'b0, 2'b10, 1'b0));
      step(1);
      sht_ack = 1'b0;
      check_out();
      for (int i = 1; i <= 20; i++) begin
         expect_out("t6_no_more", pk((i < 5) ? 5'h10 : 5'h00, 1'b0, 2'b10, 1'b0));
         step(1);
         check_out();
      end
`endif

      // scoreboard must be fully drained
      n_checks++;
      assert (exp_q.size() === 0) n_pass++;
      else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d left required 0", exp_q.size());
      end

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
